// File: rtl/ap_ctrl_driver.sv
// Drives an HLS ap_ctrl_chain kernel for a run of cfg_num_trans transactions, limiting outstanding starts.
// Optional latency statistics are built when AP_CTRL_DRV_LATENCY_EN is defined.
module ap_ctrl_driver #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned LAT_W   = 32,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_go,
   input  logic [CNT_W-1:0] cfg_num_trans,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             run_done,
   output logic [CNT_W-1:0] trans_started,
   output logic [CNT_W-1:0] trans_done,
   output logic             err_proto,
   output logic [LAT_W-1:0] last_latency,
   output logic [LAT_W-1:0] max_latency
);

   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
   localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] num_trans;
   logic [OUT_W-1:0] outstanding;
   logic             hs;
   logic             vdone;
   logic             go;
   logic [CNT_W-1:0] started_nxt;
   logic [CNT_W-1:0] done_nxt;

   always_comb begin
      ap_start    = 1'b0;
      busy        = 1'b0;
      run_done    = 1'b0;
      state_nxt   = state;

      ap_start    = (state == START) && (outstanding < MAX_OUT_V);
      busy        = (state == START) || (state == DRAIN);
      run_done    = (state == DONE);
      ap_continue = busy;

      hs          = ap_start & ap_ready;
      vdone       = ap_done & ap_continue & (outstanding != '0);
      go          = (state == IDLE) & cmd_go;
      started_nxt = trans_started + CNT_W'(hs);
      done_nxt    = trans_done + CNT_W'(vdone);

      // Completion checks use the post-update count so DONE follows the final completion directly.
      case (state)
         IDLE:  if (cmd_go) state_nxt = (cfg_num_trans != '0) ? START : DONE;
         START: if (hs && (started_nxt == num_trans))
                   state_nxt = (done_nxt == num_trans) ? DONE : DRAIN;
         DRAIN: if (done_nxt == num_trans) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         num_trans     <= '0;
         outstanding   <= '0;
         trans_started <= '0;
         trans_done    <= '0;
         err_proto     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go) begin
            num_trans     <= cfg_num_trans;
            outstanding   <= '0;
            trans_started <= '0;
            trans_done    <= '0;
         end else begin
            trans_started <= started_nxt;
            trans_done    <= done_nxt;
            if (hs && !vdone)
               outstanding <= outstanding + OUT_W'(1);
            else if (!hs && vdone)
               outstanding <= outstanding - OUT_W'(1);
         end
         // A stray done in the cmd_go cycle still flags the new run.
         if (ap_done && !vdone)
            err_proto <= 1'b1;
         else if (go)
            err_proto <= 1'b0;
      end
   end

`ifdef AP_CTRL_DRV_LATENCY_EN
   localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [LAT_W-1:0] cycle_cnt;
   logic [LAT_W-1:0] ts_fifo [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LAT_W-1:0] lat_now;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb lat_now = cycle_cnt - ts_fifo[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycle_cnt    <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         last_latency <= '0;
         max_latency  <= '0;
         for (int unsigned i = 0; i < MAX_OUT; i++)
            ts_fifo[i] <= '0;
      end else if (go) begin
         cycle_cnt    <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         last_latency <= '0;
         max_latency  <= '0;
      end else begin
         if (cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + LAT_W'(1);
         if (hs) begin
            ts_fifo[wr_ptr] <= cycle_cnt;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (vdone) begin
            rd_ptr       <= ptr_inc(rd_ptr);
            last_latency <= lat_now;
            if (lat_now > max_latency)
               max_latency <= lat_now;
         end
      end
   end
`else
   always_comb begin
      last_latency = '0;
      max_latency  = '0;
   end
`endif

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Scoreboard bench for ap_ctrl_driver: expected run results are queued at cmd_go and checked on run_done.
`timescale 1ns/1ps
module tb_ap_ctrl_driver;

   localparam int CNT_W = 16;
   localparam int LAT_W = 32;

   typedef struct {
      int started;
      int done;
      int err;
      int last_l;
      int max_l;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // main instance, MAX_OUT = 4
   logic             cmd_go, ap_start, ap_ready, ap_done, ap_continue, busy, run_done, err_proto;
   logic [CNT_W-1:0] cfg_num_trans, trans_started, trans_done;
   logic [LAT_W-1:0] last_latency, max_latency;
   logic             k_done, man_done, k_en;
   int               k_delay;
   assign ap_done = k_done | man_done;

   // second instance, MAX_OUT = 2
   logic             cmd_go2, ap_start2, ap_ready2, ap_done2, ap_continue2, busy2, run_done2, err_proto2;
   logic [CNT_W-1:0] cfg_num_trans2, trans_started2, trans_done2;
   logic [LAT_W-1:0] last_latency2, max_latency2;
   logic             k2_en;

   ap_ctrl_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_OUT(4)) u_dut (
      .clock(clock), .reset(reset), .cmd_go(cmd_go), .cfg_num_trans(cfg_num_trans),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .busy(busy), .run_done(run_done), .trans_started(trans_started), .trans_done(trans_done),
      .err_proto(err_proto), .last_latency(last_latency), .max_latency(max_latency)
   );

   ap_ctrl_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_OUT(2)) u_dut2 (
      .clock(clock), .reset(reset), .cmd_go(cmd_go2), .cfg_num_trans(cfg_num_trans2),
      .ap_start(ap_start2), .ap_ready(ap_ready2), .ap_done(ap_done2), .ap_continue(ap_continue2),
      .busy(busy2), .run_done(run_done2), .trans_started(trans_started2), .trans_done(trans_done2),
      .err_proto(err_proto2), .last_latency(last_latency2), .max_latency(max_latency2)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q1[$];
   exp_t exp_q2[$];
   exp_t e1, e2;
   int   run_cnt1 = 0, run_cnt2 = 0, start_seen1 = 0;

   function automatic void chk(string name, longint unsigned act, longint unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic int lat(int v);
`ifdef AP_CTRL_DRV_LATENCY_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Kernel models: always ready when enabled, done exactly k_delay cycles after each start handshake.
   initial begin : kern1
      int  due[$];
      int  cyc;
      logic hs;
      cyc = 0; ap_ready = 1'b0; k_done = 1'b0;
      forever begin
         @(negedge clock);
         hs = ap_start & ap_ready;
         @(posedge clock);
         if (reset) due.delete();
         else if (hs) due.push_back(cyc + k_delay);
         cyc++;
         #1;
         ap_ready = k_en;
         k_done   = (due.size() != 0) && (due[0] == cyc);
         if (k_done) void'(due.pop_front());
      end
   end

   initial begin : kern2
      int  due[$];
      int  cyc;
      logic hs;
      cyc = 0; ap_ready2 = 1'b0; ap_done2 = 1'b0;
      forever begin
         @(negedge clock);
         hs = ap_start2 & ap_ready2;
         @(posedge clock);
         if (reset) due.delete();
         else if (hs) due.push_back(cyc + 20);
         cyc++;
         #1;
         ap_ready2 = k2_en;
         ap_done2  = (due.size() != 0) && (due[0] == cyc);
         if (ap_done2) void'(due.pop_front());
      end
   end

   always @(negedge clock) begin
      if (ap_start) start_seen1++;
      if (run_done) begin
         run_cnt1++;
         if (exp_q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL run1_unexpected: run_done seen with no run expected");
         end else begin
            e1 = exp_q1.pop_front();
            chk("run1_started", trans_started, e1.started);
            chk("run1_done",    trans_done,    e1.done);
            chk("run1_err",     err_proto,     e1.err);
            chk("run1_last",    last_latency,  e1.last_l);
            chk("run1_max",     max_latency,   e1.max_l);
         end
      end
   end

   always @(negedge clock) begin
      if (run_done2) begin
         run_cnt2++;
         if (exp_q2.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL run2_unexpected: run_done seen with no run expected");
         end else begin
            e2 = exp_q2.pop_front();
            chk("run2_started", trans_started2, e2.started);
            chk("run2_done",    trans_done2,    e2.done);
            chk("run2_err",     err_proto2,     e2.err);
            chk("run2_last",    last_latency2,  e2.last_l);
            chk("run2_max",     max_latency2,   e2.max_l);
         end
      end
   end

   task automatic go1(input int num);
      @(posedge clock); #1 cmd_go = 1'b1; cfg_num_trans = CNT_W'(num);
      @(posedge clock); #1 cmd_go = 1'b0;
   endtask

   task automatic wait_run(input int which, input int budget);
      int c0;
      c0 = (which == 1) ? run_cnt1 : run_cnt2;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #1;
         if (((which == 1) ? run_cnt1 : run_cnt2) != c0) return;
      end
      n_cmp++; n_err++;
      $display("FAIL run%0d_timeout: run_done not seen within %0d cycles", which, budget);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, rc;
      reset = 1'b1; cmd_go = 1'b0; cfg_num_trans = '0; man_done = 1'b0; k_en = 1'b0; k_delay = 5;
      cmd_go2 = 1'b0; cfg_num_trans2 = '0; k2_en = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ap_start", ap_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ap_continue", ap_continue, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_started", trans_started, 0);
      chk("rst_done", trans_done, 0);
      chk("rst_err", err_proto, 0);
      chk("rst_last", last_latency, 0);
      chk("rst_max", max_latency, 0);
      @(posedge clock); #1 reset = 1'b0; k_en = 1'b1; k2_en = 1'b1;
      repeat (2) @(posedge clock);

      // N=3, done 5 cycles after each start
      k_delay = 5;
      exp_q1.push_back('{3, 3, 0, lat(5), lat(5)});
      go1(3);
      wait_run(1, 100);
      @(negedge clock);
      chk("run_done_one_cycle", run_done, 0);
      chk("busy_after_run", busy, 0);

      // zero-length run
      sc = start_seen1;
      exp_q1.push_back('{0, 0, 0, 0, 0});
      @(posedge clock); #1 cmd_go = 1'b1; cfg_num_trans = '0;
      @(negedge clock);
      chk("zero_run_not_yet", run_done, 0);
      @(posedge clock); #1 cmd_go = 1'b0;
      @(negedge clock);
      chk("zero_run_pulse", run_done, 1);
      repeat (3) @(negedge clock);
      chk("zero_run_no_start", start_seen1 - sc, 0);

      // stray ap_done in IDLE, then cleared by the next run
      @(posedge clock); #1 man_done = 1'b1;
      @(posedge clock); #1 man_done = 1'b0;
      @(negedge clock);
      chk("idle_done_err", err_proto, 1);
      chk("idle_done_not_counted", trans_done, 0);
      k_delay = 2;
      exp_q1.push_back('{1, 1, 0, lat(2), lat(2)});
      go1(1);
      @(negedge clock);
      chk("err_cleared_by_go", err_proto, 0);
      wait_run(1, 50);

      // same-cycle ready and done with one outstanding
      k_delay = 1;
      exp_q1.push_back('{2, 2, 0, lat(1), lat(1)});
      go1(2);
      @(posedge clock); @(posedge clock); @(negedge clock);
      chk("overlap_started", trans_started, 2);
      chk("overlap_done", trans_done, 1);
      chk("overlap_busy", busy, 1);
      chk("overlap_drain_no_start", ap_start, 0);
      wait_run(1, 50);

      // reset in DRAIN with two outstanding
      k_delay = 10;
      go1(2);
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("midrst_ap_start", ap_start, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ap_continue", ap_continue, 0);
      chk("midrst_started", trans_started, 0);
      chk("midrst_done", trans_done, 0);
      chk("midrst_run_done", run_done, 0);
      rc = run_cnt1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (20) @(negedge clock);
      chk("midrst_no_run_done", run_cnt1 - rc, 0);

      // MAX_OUT=2 throttling, N=8, done 20 cycles after start
      exp_q2.push_back('{8, 8, 0, lat(20), lat(20)});
      @(posedge clock); #1 cmd_go2 = 1'b1; cfg_num_trans2 = CNT_W'(8);
      @(posedge clock); #1 cmd_go2 = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      chk("throttle_start_low", ap_start2, 0);
      chk("throttle_started2", trans_started2, 2);
      repeat (11) @(posedge clock);
      @(negedge clock);
      chk("throttle_first_done", ap_done2, 1);
      chk("throttle_still_low", ap_start2, 0);
      @(posedge clock); @(negedge clock);
      chk("throttle_resume", ap_start2, 1);
      wait_run(2, 400);

      repeat (2) @(negedge clock);
      chk("scoreboard_drained", exp_q1.size() + exp_q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
